i2s_transmit: RTL and testbench
===============================

# i2s_transmit

I2S master transmitter: accepts stereo PCM samples on an AXI4-Stream slave port and serialises them onto `sck`/`ws`/`sd` with standard I2S framing. The block generates `sck` from the system clock and drives `sd` with a one-`sck` delay after each `ws` transition. It is the output-side counterpart of the I2S receive path and carries the same left/right `TLAST` convention: `TLAST=1` marks the right channel.

## Interface
- `DATA_WIDTH`, 32: bits per channel slot and sample width.
- `CLK_DIV`, 8: system clocks per `sck` period. Must be even and ≥4.
- `S_AXIS_ACLK` in, 1: system clock. All logic is in this domain.
- `S_AXIS_ARESETN` in, 1: reset, synchronous, active-low.
- `S_AXIS_TDATA` in, DATA_WIDTH: signed PCM sample.
- `S_AXIS_TVALID` in, 1: sample valid.
- `S_AXIS_TREADY` out, 1: block can accept a sample.
- `S_AXIS_TLAST` in, 1: 0 = left sample, 1 = right sample.
- `sck` out, 1: I2S bit clock.
- `ws` out, 1: word select. 0 = left, 1 = right.
- `sd` out, 1: serial data, MSB first.

## Operation
- **Divider**
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `sck` = 1 when `div_cnt` ≥ CLK_DIV/2, else 0.
  - `fall` strobe fires on the cycle `div_cnt` wraps to 0.
- **Input FIFO**
  - 2-entry FIFO of {TLAST, TDATA}.
  - `S_AXIS_TREADY` = !full. It is 0 while in reset.
  - Push occurs on `TVALID && TREADY`.
  - A pop in the same cycle does not raise `TREADY`; `TREADY` depends only on the registered count.
- **Bit counter**
  - `bit_cnt` runs 0..DATA_WIDTH-1 and advances on each `fall`.
- **On `fall` with `bit_cnt == DATA_WIDTH-1` (slot boundary)**
  - `ws` toggles.
  - `sd` is driven with the current shift MSB, which is the LSB of the outgoing word.
  - The shift register is reloaded for the new channel (new `ws` value):
    - FIFO non-empty and head TLAST == new `ws`: load head, pop.
    - FIFO empty: load 0 (underrun).
    - Head TLAST != new `ws`: load 0 without popping (sync error). The mismatched head is consumed at the next matching slot, so the stream self-resyncs.
- **On any other `fall`**
  - `sd` ← shift MSB.
  - Shift register shifts left by one, with a 0 fill.
- Result: word bits W[DW-1]..W[0] appear on `sd` during the DW `sck` periods that start one `sck` after the `ws` edge.

## Timing
- **Reset values:** `sck`=0, `ws`=1, `sd`=0, `S_AXIS_TREADY`=0, FIFO empty, `div_cnt`=0, `bit_cnt`=DATA_WIDTH-1, shift register 0.
  - The first `fall` after reset is therefore a slot boundary: `ws`→0 (left).
- **Output registration:** `sck`, `ws` and `sd` are registered and change only on system clock edges. `ws` and `sd` change only on the `fall` cycle, i.e. with `sck` falling.
- **Frame period:** 2·DATA_WIDTH·CLK_DIV system clocks (512 at defaults).
- **Latency:** a sample pushed into an empty FIFO at least one cycle before a matching slot boundary has its MSB on `sd` at the following `fall`. That is CLK_DIV clocks after the boundary.
- **Reset asserted mid-frame:** all state returns to reset values on the next clock. FIFO contents are discarded and no partial word is completed.
- **Simultaneous push and boundary pop:** both take effect; the count is unchanged.

## Configuration
- `I2S_TX_STATUS_EN` defined:
  - Adds output `underrun` (1-cycle pulse on each empty-FIFO boundary).
  - Adds output `sync_err` (1-cycle pulse on each TLAST/`ws` mismatch boundary).
  - Adds output `underrun_count` [15:0], saturating at 16'hFFFF.
  - Reset value of all three is 0.
- `I2S_TX_STATUS_EN` undefined: these ports and their logic are absent. Serial behaviour is identical in both builds.

## Structure
- Shared package `i2s_pkg`:
  - Channel constants `I2S_LEFT`=0 and `I2S_RIGHT`=1, used by both receive and transmit.
  - Default width constant `I2S_DEFAULT_WIDTH`=32.
- Sub-module `i2s_sck_gen`: divider producing `sck`, `fall` and `rise` strobes, parameterised by CLK_DIV. It is reusable by a future master-mode receiver.
- FIFO and shift logic stay inline.

## Test plan
All scenarios use DATA_WIDTH=32 and CLK_DIV=8.
- **Reset:** hold `S_AXIS_ARESETN`=0 for 10 clocks → `sck`=0, `ws`=1, `sd`=0, `TREADY`=0. After release `TREADY`=1 the next cycle, and the first `fall` drives `ws`=0.
- **Stereo frame:** push L=32'hA5000001 (TLAST=0), then R=32'h8000FFFF (TLAST=1) → a receiver model sampling `sd` on `sck` rise recovers both words exactly, with R during `ws`=1. The next `ws` edge falls 256 clocks after the previous one.
- **Backpressure:** push 3 samples back-to-back → `TREADY` drops after the 2nd push and returns on the cycle after the first boundary pop.
- **Underrun:** no input after one frame → `sd`=0 for the whole next frame. With `I2S_TX_STATUS_EN`, 2 `underrun` pulses and `underrun_count`=2.
- **Sync error:** push a TLAST=1 sample first → left slot transmits 0 with a `sync_err` pulse, and the sample appears in the following right slot.
- **Reset mid-word:** assert reset after 10 bits of a word → outputs return to reset values, and the FIFO is empty (`TREADY`=1 after release).

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit and receive paths: channel encoding,
// default slot width and the slot-boundary load classification.
package i2s_pkg;

  localparam logic I2S_LEFT          = 1'b0;
  localparam logic I2S_RIGHT         = 1'b1;
  localparam int   I2S_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    LOAD_SAMPLE   = 2'd0,
    LOAD_UNDERRUN = 2'd1,
    LOAD_SYNC_ERR = 2'd2
  } load_kind_e;

  // A queued head only leaves the FIFO in a slot of its own channel; a mismatched
  // head waits for the next matching slot so the stream resynchronises itself.
  function automatic load_kind_e classify_slot(input logic [1:0] count,
                                               input logic       head_last,
                                               input logic       new_ws);
    if (count == 2'd0) begin
      return LOAD_UNDERRUN;
    end else if (head_last != new_ws) begin
      return LOAD_SYNC_ERR;
    end
    return LOAD_SAMPLE;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock divider: registered sck plus single-cycle fall/rise strobes that
// mark the system clock edges on which sck falls and rises.
module i2s_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic fall,
  output logic rise
);

  localparam int              CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV / 2 - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_nxt;

  always_comb begin
    fall    = (div_cnt == LAST);
    rise    = (div_cnt == RISE_AT);
    div_nxt = fall ? '0 : div_cnt + 1'b1;
  end

  // sck is registered from the next count so it always equals (div_cnt >= HALF)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      sck     <= (div_nxt >= HALF);
    end
  end

endmodule

// File: rtl/i2s_transmit.sv
// I2S master transmitter: AXI4-Stream stereo samples (TLAST=1 marks right) through a
// 2-entry FIFO onto sck/ws/sd. Define I2S_TX_STATUS_EN to add underrun/sync status ports.
module i2s_transmit
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DEFAULT_WIDTH,
  parameter int CLK_DIV    = 8
) (
  input  logic                         S_AXIS_ACLK,
  input  logic                         S_AXIS_ARESETN,
  input  logic signed [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic                         S_AXIS_TLAST,
  output logic                         sck,
  output logic                         ws,
  output logic                         sd
`ifdef I2S_TX_STATUS_EN
  ,
  output logic                         underrun,
  output logic                         sync_err,
  output logic [15:0]                  underrun_count
`endif
);

  localparam int               BIT_W    = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic                         fall;
  logic                         rise_unused;
  logic signed [DATA_WIDTH-1:0] fifo_data [2];
  logic                         fifo_last [2];
  logic                         rd_ptr;
  logic                         wr_ptr;
  logic [1:0]                   count;
  logic                         active;
  logic [BIT_W-1:0]             bit_cnt;
  logic signed [DATA_WIDTH-1:0] shift;
  logic                         push;
  logic                         pop;
  logic                         boundary;
  logic                         new_ws;
  load_kind_e                   kind;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk   (S_AXIS_ACLK),
    .rst_n (S_AXIS_ARESETN),
    .sck   (sck),
    .fall  (fall),
    .rise  (rise_unused)
  );

  // Ready comes from registered state only, so a same-cycle pop never opens it early
  assign S_AXIS_TREADY = active && (count != 2'd2);

  always_comb begin
    push     = S_AXIS_TVALID && S_AXIS_TREADY;
    boundary = fall && (bit_cnt == LAST_BIT);
    new_ws   = (ws == I2S_LEFT) ? I2S_RIGHT : I2S_LEFT;
    kind     = classify_slot(count, fifo_last[rd_ptr], new_ws);
    pop      = boundary && (kind == LOAD_SAMPLE);
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) begin
      fifo_data[wr_ptr] <= S_AXIS_TDATA;
      fifo_last[wr_ptr] <= S_AXIS_TLAST;
    end
  end

  // On the slot boundary sd takes the outgoing LSB while the shifter reloads
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      active  <= 1'b0;
      count   <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      bit_cnt <= LAST_BIT;
      ws      <= I2S_RIGHT;
      sd      <= 1'b0;
      shift   <= '0;
    end else begin
      active <= 1'b1;
      count  <= count + 2'(push) - 2'(pop);
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (fall) begin
        sd <= shift[DATA_WIDTH-1];
        if (boundary) begin
          ws      <= new_ws;
          bit_cnt <= '0;
          shift   <= (kind == LOAD_SAMPLE) ? fifo_data[rd_ptr] : '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shift   <= {shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

`ifdef I2S_TX_STATUS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      underrun       <= 1'b0;
      sync_err       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= boundary && (kind == LOAD_UNDERRUN);
      sync_err <= boundary && (kind == LOAD_SYNC_ERR);
      if (boundary && (kind == LOAD_UNDERRUN)) begin
        underrun_count <= sat_inc16(underrun_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_transmit.sv
// Directed bench for i2s_transmit: samples queued on send, recovered by an I2S
// receiver model on sck rise and compared per slot.
module tb_i2s_transmit;

  localparam int DW = 32;
  localparam int CD = 8;

  typedef struct {
    logic        ch;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        sck;
  logic        ws;
  logic        sd;
`ifdef I2S_TX_STATUS_EN
  logic        underrun;
  logic        sync_err;
  logic [15:0] underrun_count;
`endif

  int  passed = 0;
  int  total = 0;
  int  failed = 0;
  int  cyc = 0;
  int  words_done = 0;
  int  last_edge = 0;
  int  ur_pulses = 0;
  int  sync_pulses = 0;
  int  ws_edges[$];
  sb_t sb[$];

  always #5 clk = ~clk;

  i2s_transmit #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CD)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rstn),
    .S_AXIS_TDATA   (tdata),
    .S_AXIS_TVALID  (tvalid),
    .S_AXIS_TREADY  (tready),
    .S_AXIS_TLAST   (tlast),
    .sck            (sck),
    .ws             (ws),
    .sd             (sd)
`ifdef I2S_TX_STATUS_EN
    ,
    .underrun       (underrun),
    .sync_err       (sync_err),
    .underrun_count (underrun_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axis_send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    while (tready !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("send_accepted", n < 1000, 1'b1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    sb.push_back('{ch: l, data: d, cyc: cyc});
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (words_done < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("words_arrived", words_done >= target, 1'b1);
  endtask

  task automatic wait_ws(input logic v);
    int n;
    n = 0;
    while (ws !== v && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("ws_reached", ws === v, 1'b1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ws edge log and status pulse counters, sampled mid-cycle
  initial begin
    logic prev_ws;
    prev_ws = 1'b1;
    forever begin
      @(negedge clk);
      if (ws !== prev_ws) begin
        ws_edges.push_back(cyc);
        last_edge = cyc;
      end
      prev_ws = ws;
`ifdef I2S_TX_STATUS_EN
      if (underrun === 1'b1) ur_pulses++;
      if (sync_err === 1'b1) sync_pulses++;
`endif
    end
  end

  // Receiver: a slot's word is the DW bits sampled on sck rise, ending with the
  // rise just after the next ws edge. Queued words only count for slots that began
  // after they were accepted and that carry their channel; anything else must be 0.
  initial begin
    logic        last_ws_m;
    logic [31:0] acc;
    logic [31:0] word;
    logic [31:0] exp_w;
    int          cnt_m;
    int          slot_start;
    last_ws_m  = 1'b1;
    acc        = '0;
    cnt_m      = 0;
    slot_start = 0;
    forever begin
      @(posedge sck);
      word = {acc[30:0], sd};
      if (ws !== last_ws_m) begin
        if (cnt_m == DW - 1) begin
          exp_w = 32'd0;
          if (sb.size() > 0 && sb[0].ch == last_ws_m && sb[0].cyc < slot_start) begin
            exp_w = sb[0].data;
            sb.delete(0);
          end
          chk(last_ws_m ? "right_word" : "left_word", word, exp_w);
          words_done++;
        end
        cnt_m      = 0;
        last_ws_m  = ws;
        slot_start = last_edge;
      end else begin
        cnt_m++;
      end
      acc = word;
    end
  end

  initial begin
    int   c0;
    int   n;
    int   s0;
    logic tr_prev;

    rstn   = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;

    // Reset
    tick(10);
    chk1("rst_sck", sck, 1'b0);
    chk1("rst_ws", ws, 1'b1);
    chk1("rst_sd", sd, 1'b0);
    chk1("rst_tready", tready, 1'b0);
`ifdef I2S_TX_STATUS_EN
    chk("rst_underrun_count", {16'd0, underrun_count}, 32'd0);
`endif
    rstn = 1'b1;
    c0 = cyc;
    ws_edges.delete();
    tick(1);
    chk1("tready_after_release", tready, 1'b1);

    // Stereo frame
    axis_send(32'hA5000001, 1'b0);
    axis_send(32'h8000FFFF, 1'b1);
    wait_words(2);
    chk1("ws_edges_seen", ws_edges.size() >= 3, 1'b1);
    if (ws_edges.size() >= 3) begin
      chk("first_fall_ws_edge", ws_edges[0] - c0, CD);
      chk("ws_gap_left", ws_edges[1] - ws_edges[0], DW * CD);
      chk("ws_gap_right", ws_edges[2] - ws_edges[1], DW * CD);
    end

    // Underrun frame
    wait_words(3);
`ifdef I2S_TX_STATUS_EN
    chk("underrun_count", {16'd0, underrun_count}, 32'd2);
    chk("underrun_pulses", ur_pulses, 32'd2);
`endif
    wait_words(4);

    // Backpressure
    wait_ws(1'b1);
    axis_send(32'h12345678, 1'b0);
    chk1("bp_ready_after_1", tready, 1'b1);
    axis_send(32'hFEDCBA98, 1'b1);
    chk1("bp_ready_after_2", tready, 1'b0);
    tdata   = 32'h7FFFFFFF;
    tlast   = 1'b0;
    tvalid  = 1'b1;
    n       = 0;
    tr_prev = tready;
    while (ws !== 1'b0 && n < 600) begin
      tr_prev = tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk1("bp_boundary_seen", n < 600, 1'b1);
    chk1("bp_ready_before_pop", tr_prev, 1'b0);
    chk1("bp_ready_after_pop", tready, 1'b1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    sb.push_back('{ch: 1'b0, data: 32'h7FFFFFFF, cyc: cyc});
    chk1("bp_ready_refilled", tready, 1'b0);
    wait_words(9);

    // Sync error: right-tagged sample offered ahead of a left slot
    wait_ws(1'b1);
    s0 = sync_pulses;
    axis_send(32'h80000000, 1'b1);
    wait_words(12);
    chk("sb_drained", sb.size(), 32'd0);
`ifdef I2S_TX_STATUS_EN
    chk("sync_err_pulses", sync_pulses - s0, 32'd1);
`endif

    // Reset mid-word with a full FIFO
    wait_ws(1'b1);
    axis_send(32'hC3C3C3C3, 1'b0);
    wait_ws(1'b0);
    axis_send(32'h0F0F0F0F, 1'b1);
    axis_send(32'h00000001, 1'b0);
    chk1("fifo_full_before_reset", tready, 1'b0);
    tick(80);
    rstn = 1'b0;
    tick(1);
    chk1("midrst_sck", sck, 1'b0);
    chk1("midrst_ws", ws, 1'b1);
    chk1("midrst_sd", sd, 1'b0);
    chk1("midrst_tready", tready, 1'b0);
`ifdef I2S_TX_STATUS_EN
    chk("midrst_underrun_count", {16'd0, underrun_count}, 32'd0);
    chk1("midrst_sync_err", sync_err, 1'b0);
`endif
    sb.delete();
    tick(2);
    rstn = 1'b1;
    c0 = cyc;
    ws_edges.delete();
    tick(1);
    chk1("midrst_tready_release", tready, 1'b1);
    n = words_done;
    wait_words(n + 2);
    chk1("midrst_ws_edge_seen", ws_edges.size() >= 1, 1'b1);
    if (ws_edges.size() >= 1) begin
      chk("midrst_first_fall", ws_edges[0] - c0, CD);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
